// File: rtl/game_pkg.sv
// Shared game-logic types: magnet FSM states, energy width and saturating
// energy arithmetic helpers.
package game_pkg;

  localparam int unsigned ENERGY_W = 8;

  typedef logic [ENERGY_W-1:0] energy_t;

  typedef enum logic [1:0] {
    MG_IDLE,
    MG_ARMED,
    MG_LOCKED,
    MG_COOLDOWN
  } magnet_state_t;

  // Subtract, clamping at zero.
  function automatic energy_t sat_sub(energy_t a, energy_t b);
    return (a > b) ? energy_t'(a - b) : '0;
  endfunction

  // Add, clamping at lim.
  function automatic energy_t sat_add(energy_t a, energy_t b, energy_t lim);
    logic [ENERGY_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : energy_t'(sum);
  endfunction

endpackage

// File: rtl/magnet_arbiter_if.sv
// Magnet arbiter bus: keyboard/collision inputs towards the arbiter and the
// per-machine enables plus status back to the movement and HUD logic.
interface magnet_arbiter_if #(
  parameter int unsigned NUM_MACHINES = 4
);
  import game_pkg::*;

  localparam int unsigned GRANT_W = $clog2(NUM_MACHINES);

  logic                    startOfFrame;
  logic                    game_active;
  logic                    magnet_key;
  logic [NUM_MACHINES-1:0] collision_doc;
  logic [NUM_MACHINES-1:0] magnet_on;
  logic [GRANT_W-1:0]      grant_id;
  logic                    magnet_active;
  logic                    armed;
  logic                    cooldown;
  energy_t                 energy;

  modport master (
    output startOfFrame, game_active, magnet_key, collision_doc,
    input  magnet_on, grant_id, magnet_active, armed, cooldown, energy
  );

  modport slave (
    input  startOfFrame, game_active, magnet_key, collision_doc,
    output magnet_on, grant_id, magnet_active, armed, cooldown, energy
  );

endinterface

// File: rtl/magnet_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after last,
// wrapping modulo N. Generic so other shared resources can reuse it.
module rr_picker #(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    int unsigned k;
    k     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      k = 32'(last) + off;
      if (k >= N) k = k - N;
      if (!valid && req[W'(k)]) begin
        valid = 1'b1;
        idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/magnet_arbiter.sv
// Doctor's magnet sequencer: arms on key, locks one machine round-robin on
// contact, and runs the drain / recharge / cooldown energy budget.
module magnet_arbiter
  import game_pkg::*;
#(
  parameter int unsigned NUM_MACHINES       = 4,
  parameter int unsigned ENERGY_MAX         = 255,
  parameter int unsigned ARM_THRESHOLD      = 32,
  parameter int unsigned DRAIN_PER_FRAME    = 2,
  parameter int unsigned ARMED_DRAIN        = 1,
  parameter int unsigned RECHARGE_PER_FRAME = 1,
  parameter int unsigned COOLDOWN_FRAMES    = 60
) (
  input  logic             clk,
  input  logic             resetN,
  magnet_arbiter_if.slave  bus
);

  localparam int unsigned GRANT_W = $clog2(NUM_MACHINES);
  localparam int unsigned CD_W    = $clog2(COOLDOWN_FRAMES + 1);

  localparam energy_t E_MAX      = energy_t'(ENERGY_MAX);
  localparam energy_t E_ARM      = energy_t'(ARM_THRESHOLD);
  localparam energy_t E_DRAIN    = energy_t'(DRAIN_PER_FRAME);
  localparam energy_t E_ARMDRAIN = energy_t'(ARMED_DRAIN);
  localparam energy_t E_RECHARGE = energy_t'(RECHARGE_PER_FRAME);

  magnet_state_t           state_q, state_d;
  energy_t                 energy_q, energy_d;
  logic [CD_W-1:0]         cd_q, cd_d;
  logic [GRANT_W-1:0]      last_q, last_d;
  logic [GRANT_W-1:0]      grant_q, grant_d;
  logic [NUM_MACHINES-1:0] on_q, on_d;
  logic                    active_q, armed_q, cool_q;

  logic [GRANT_W-1:0]      pick_idx;
  logic                    pick_valid;

  rr_picker #(
    .N (NUM_MACHINES)
  ) u_picker (
    .req   (bus.collision_doc),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Next state, energy budget and grant selection.
  always_comb begin
    state_d  = state_q;
    energy_d = energy_q;
    cd_d     = cd_q;
    last_d   = last_q;
    grant_d  = grant_q;
    on_d     = '0;

    unique case (state_q)
      MG_IDLE: begin
        if (bus.game_active && bus.startOfFrame)
          energy_d = sat_add(energy_q, E_RECHARGE, E_MAX);
        if (bus.game_active && bus.magnet_key && (energy_q >= E_ARM))
          state_d = MG_ARMED;
      end

      MG_ARMED: begin
        if (!bus.game_active) begin
          state_d = MG_IDLE;
        end else begin
          if (bus.startOfFrame)
            energy_d = sat_sub(energy_q, E_ARMDRAIN);
          if (bus.startOfFrame && (energy_d == '0)) begin
            state_d = MG_COOLDOWN;
            cd_d    = CD_W'(COOLDOWN_FRAMES);
          end else if (!bus.magnet_key) begin
            state_d = MG_IDLE;
          end else if (pick_valid) begin
            state_d = MG_LOCKED;
            grant_d = pick_idx;
            last_d  = pick_idx;
          end
        end
      end

      // Contact may be lost while locked; the grant is held regardless.
      MG_LOCKED: begin
        if (!bus.game_active) begin
          state_d = MG_IDLE;
        end else begin
          if (bus.startOfFrame)
            energy_d = sat_sub(energy_q, E_DRAIN);
          if (bus.startOfFrame && (energy_d == '0)) begin
            state_d = MG_COOLDOWN;
            cd_d    = CD_W'(COOLDOWN_FRAMES);
          end else if (!bus.magnet_key) begin
            state_d = MG_IDLE;
          end
        end
      end

      MG_COOLDOWN: begin
        if (bus.startOfFrame) begin
          if (cd_q <= CD_W'(1)) begin
            cd_d    = '0;
            state_d = MG_IDLE;
          end else begin
            cd_d = cd_q - CD_W'(1);
          end
        end
      end

      default: state_d = MG_IDLE;
    endcase

    if (state_d == MG_LOCKED)
      on_d[grant_d] = 1'b1;
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= MG_IDLE;
      energy_q <= E_MAX;
      cd_q     <= '0;
      last_q   <= GRANT_W'(NUM_MACHINES - 1);
      grant_q  <= '0;
      on_q     <= '0;
      active_q <= 1'b0;
      armed_q  <= 1'b0;
      cool_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      energy_q <= energy_d;
      cd_q     <= cd_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      on_q     <= on_d;
      active_q <= (state_d == MG_LOCKED);
      armed_q  <= (state_d == MG_ARMED);
      cool_q   <= (state_d == MG_COOLDOWN);
    end
  end

  assign bus.magnet_on     = on_q;
  assign bus.grant_id      = grant_q;
  assign bus.magnet_active = active_q;
  assign bus.armed         = armed_q;
  assign bus.cooldown      = cool_q;
  assign bus.energy        = energy_q;

endmodule
